// File: rtl/rpspmc_stream_pkg.sv
// Shared definitions for the streaming post-processing blocks that sit
// behind the biquad IIR stage.
package rpspmc_stream_pkg;

    localparam int SAMPLE_WIDTH   = 32;
    localparam int CFG_WORD_WIDTH = 32;
    localparam int WORD_LOG2_DEC  = 0;
    localparam int ENABLE_BIT     = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

endpackage

// File: rtl/axis_round_shift_sat.sv
// Combinational arithmetic right shift with round-half-up (toward +inf)
// and saturation to a narrower signed output word.
module axis_round_shift_sat #(
    parameter int in_width    = 48,
    parameter int out_width   = 32,
    parameter int shift_width = 5
) (
    input  logic [in_width-1:0]    din,
    input  logic [shift_width-1:0] shift,
    output logic [out_width-1:0]   dout
);
    // One guard bit so adding the rounding constant can never wrap.
    localparam int ext_width = in_width + 1;

    logic        [ext_width-1:0] round_bit;
    logic signed [ext_width-1:0] biased;
    logic signed [ext_width-1:0] shifted;
    logic signed [ext_width-1:0] max_v;
    logic signed [ext_width-1:0] min_v;

    // Rounding constant is 2^(shift-1), which collapses to 0 when shift is 0.
    assign round_bit = (ext_width'(1) << shift) >> 1;
    assign biased    = $signed({din[in_width-1], din}) + $signed(round_bit);
    assign shifted   = biased >>> shift;
    assign max_v     = ext_width'({1'b0, {(out_width-1){1'b1}}});
    assign min_v     = ~max_v;

    // Clamp anything outside the output range to the nearest code.
    always_comb begin
        dout = shifted[out_width-1:0];
        if (shifted > max_v) begin
            dout = max_v[out_width-1:0];
        end else if (shifted < min_v) begin
            dout = min_v[out_width-1:0];
        end
    end

endmodule

// File: rtl/axis_iir_decimating_averager.sv
// Boxcar decimator: sums 2^K valid samples and emits one rounded mean per
// block, one clock after the block's last sample.
//
// state | meaning
// IDLE  | after reset or config write; inputs ignored, waits for enable
// ACCUM | accumulating samples of the current block
// DUMP  | output strobe cycle; new block already accumulating
module axis_iir_decimating_averager
    import rpspmc_stream_pkg::*;
#(
    parameter int inout_width             = SAMPLE_WIDTH,
    parameter int max_log2_decimation     = 16,
    parameter int default_log2_decimation = 0,
    parameter int configuration_address   = 998
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [31:0]                  config_addr,
    input  logic [511:0]                 config_data,
    input  logic [inout_width-1:0]       S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    output logic [inout_width-1:0]       M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    output logic [max_log2_decimation:0] sample_count
);
    localparam int acc_width = inout_width + max_log2_decimation;
    localparam int cnt_width = max_log2_decimation + 1;

    state_t                      state;
    state_t                      state_next;
    logic [4:0]                  log2_dec;
    logic                        enable;
    logic signed [acc_width-1:0] acc;
    logic signed [acc_width-1:0] block_sum;
    logic [cnt_width-1:0]        count;
    logic [cnt_width-1:0]        count_inc;
    logic [cnt_width-1:0]        block_len;
    logic [inout_width-1:0]      mean;
    logic [CFG_WORD_WIDTH-1:0]   cfg_word;
    logic [4:0]                  cfg_log2;
    logic                        cfg_hit;
    logic                        accepting;
    logic                        block_done;
    logic                        cfg_unused;

    assign cfg_hit  = (config_addr == 32'(configuration_address));
    assign cfg_word = config_data[WORD_LOG2_DEC*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
    assign cfg_log2 = (cfg_word[4:0] > 5'(max_log2_decimation)) ?
                      5'(max_log2_decimation) : cfg_word[4:0];
    // Only the K and enable fields of word 0 are meaningful here.
    assign cfg_unused = ^{config_data[511:CFG_WORD_WIDTH], cfg_word[30:5]};

    // A config write in the same cycle wins, so the sample is dropped.
    assign accepting  = S_AXIS_tvalid && !cfg_hit && (state != IDLE);
    assign count_inc  = count + cnt_width'(1);
    assign block_len  = cnt_width'(1) << log2_dec;
    assign block_done = accepting && (count_inc == block_len);
    // Completed sum includes the closing sample; it is consumed directly by
    // the rounder so the accumulator is free to restart in the same cycle.
    assign block_sum  = acc + {{max_log2_decimation{S_AXIS_tdata[inout_width-1]}},
                               S_AXIS_tdata};

    axis_round_shift_sat #(
        .in_width   (acc_width),
        .out_width  (inout_width),
        .shift_width(5)
    ) u_round (
        .din  (block_sum),
        .shift(log2_dec),
        .dout (mean)
    );

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DUMP accepts samples exactly like ACCUM so that
    // back-to-back input is sustained even for K=0.
    always_comb begin
        state_next = state;
        if (cfg_hit) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:        state_next = enable ? ACCUM : IDLE;
                ACCUM, DUMP: state_next = block_done ? DUMP : ACCUM;
                default:     state_next = IDLE;
            endcase
        end
    end

    // Accumulator, configuration and registered output word/strobe.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc           <= '0;
            count         <= '0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
            log2_dec      <= 5'(default_log2_decimation);
            enable        <= 1'b1;
        end else begin
            M_AXIS_tvalid <= block_done;
            if (block_done) begin
                M_AXIS_tdata <= mean;
            end
            if (cfg_hit) begin
                log2_dec <= cfg_log2;
                enable   <= cfg_word[ENABLE_BIT];
                acc      <= '0;
                count    <= '0;
            end else if (block_done) begin
                acc   <= '0;
                count <= '0;
            end else if (accepting) begin
                acc   <= block_sum;
                count <= count_inc;
            end
        end
    end

    assign sample_count = count;

endmodule
